// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
package arb_pkg;

  localparam int NREQ   = 4;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter4_if.sv
// Requester-side bundle of the arbiter: request/done in, grant status out.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_id;
  logic            gnt_vld;
  logic            timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_vld,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_vld,
    output timeout
  );

endinterface

// File: rtl/rr_prio_enc4.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping.
module rr_prio_enc4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      id,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [1:0]        pos;

  // Rotate so ptr lands at bit 0, pick the lowest set bit, then rotate back.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    pos = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = 2'(i);
    end
    any = |req;
    id  = pos + ptr;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with done/drop/hold-limit release.
//
// state | meaning
// IDLE  | no owner; arbitrate among requests at the next edge
// GRANT | one requester owns the resource; watch for release
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter4_if.slave  bus
);

  localparam logic              HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [1:0]        gnt_id_q, gnt_id_d;
  logic              gnt_vld_q, gnt_vld_d;
  logic              timeout_q, timeout_d;

  logic [1:0]        win_id;
  logic              win_any;
  logic              hold_hit;
  logic              owner_req;
  logic              release_c;

  rr_prio_enc4 u_enc (
    .req (bus.req),
    .ptr (ptr_q),
    .id  (win_id),
    .any (win_any)
  );

  // State, pointer, hold counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= 2'd0;
      gnt_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      gnt_vld_q  <= gnt_vld_d;
      timeout_q  <= timeout_d;
    end
  end

  // Arbitrate in IDLE; in GRANT release on done, request drop or hold expiry.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    gnt_vld_d  = gnt_vld_q;
    timeout_d  = 1'b0;

    hold_hit  = HOLD_EN && (hold_cnt_q == HOLD_LAST);
    owner_req = bus.req[gnt_id_q];
    release_c = bus.done || !owner_req || hold_hit;

    case (state_q)
      IDLE: begin
        if (win_any) begin
          gnt_d      = NREQ'(1) << win_id;
          gnt_id_d   = win_id;
          gnt_vld_d  = 1'b1;
          ptr_d      = win_id + 2'd1;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (release_c) begin
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          state_d   = IDLE;
          // A done or drop on the expiry edge makes this an ordinary release.
          timeout_d = hold_hit && !bus.done && owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed and randomized bench for rr_arbiter4 against an ownership-level model.
module tb_rr_arbiter4;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rr_arbiter4_if tif ();

  rr_arbiter4 #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the resource, for how many cycles, and where the
  // next search starts.
  int m_owner;
  int m_len;
  int m_id;
  int m_start;
  bit m_to;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_len   = 0;
    m_id    = 0;
    m_start = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic d);
    int  i;
    bit  found;
    bit  expired;
    m_to  = 1'b0;
    found = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        i = (m_start + k) % 4;
        if (!found && r[i]) begin
          found   = 1'b1;
          m_owner = i;
          m_id    = i;
          m_start = (i + 1) % 4;
          m_len   = 1;
        end
      end
    end else begin
      expired = (HOLD != 0) && (m_len == HOLD);
      if (d || !r[m_owner]) begin
        m_owner = -1;
      end else if (expired) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_len++;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 8'd0 : 8'(1 << m_owner);
    chk({tag, ".gnt"},     8'(tif.gnt),     exp_gnt);
    chk({tag, ".gnt_id"},  8'(tif.gnt_id),  8'(m_id));
    chk({tag, ".gnt_vld"}, 8'(tif.gnt_vld), 8'(m_owner >= 0));
    chk({tag, ".timeout"}, 8'(tif.timeout), 8'(m_to));
  endtask

  task automatic step(input logic [3:0] r, input logic d, input string tag);
    tif.req  = r;
    tif.done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    tif.req  = 4'b0000;
    tif.done = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    int grants;
    logic [3:0] r;
    logic d;

    tif.req  = 4'b0000;
    tif.done = 1'b0;
    model_reset();

    // Reset values and a single request
    #2;
    do_reset();
    chk("rst.gnt", 8'(tif.gnt), 8'h00);
    step(4'b0100, 1'b0, "single");
    chk("single.gnt", 8'(tif.gnt), 8'h04);
    chk("single.id", 8'(tif.gnt_id), 8'h02);
    chk("single.vld", 8'(tif.gnt_vld), 8'h01);
    step(4'b0100, 1'b1, "single_done");
    chk("single_done.gnt", 8'(tif.gnt), 8'h00);
    chk("single_done.id", 8'(tif.gnt_id), 8'h02);

    // Rotation with all lines requesting
    do_reset();
    grants = 0;
    for (int n = 0; n < 10; n++) begin
      d = tif.gnt_vld;
      step(4'b1111, d, "rot");
      if (tif.gnt_vld) begin
        chk("rot.id", 8'(tif.gnt_id), 8'(grants % 4));
        grants++;
      end else begin
        chk("rot.idle", 8'(tif.gnt), 8'h00);
      end
    end
    chk("rot.count", 8'(grants), 8'd5);

    // Hold limit
    do_reset();
    for (int n = 0; n < HOLD; n++) begin
      step(4'b0011, 1'b0, "hold");
      chk("hold.gnt", 8'(tif.gnt), 8'h01);
      chk("hold.to", 8'(tif.timeout), 8'h00);
    end
    step(4'b0011, 1'b0, "hold_exp");
    chk("hold_exp.gnt", 8'(tif.gnt), 8'h00);
    chk("hold_exp.to", 8'(tif.timeout), 8'h01);
    step(4'b0011, 1'b0, "hold_next");
    chk("hold_next.gnt", 8'(tif.gnt), 8'h02);
    chk("hold_next.to", 8'(tif.timeout), 8'h00);

    // Request drop, then pointer skip from ptr=2
    step(4'b0001, 1'b0, "drop");
    chk("drop.gnt", 8'(tif.gnt), 8'h00);
    chk("drop.to", 8'(tif.timeout), 8'h00);
    step(4'b1001, 1'b0, "skip");
    chk("skip.gnt", 8'(tif.gnt), 8'h08);
    chk("skip.id", 8'(tif.gnt_id), 8'h03);

    // done on the hold-expiry edge
    for (int n = 1; n < HOLD; n++) step(4'b1001, 1'b0, "coin_wait");
    chk("coin_wait.gnt", 8'(tif.gnt), 8'h08);
    step(4'b1001, 1'b1, "coin");
    chk("coin.gnt", 8'(tif.gnt), 8'h00);
    chk("coin.to", 8'(tif.timeout), 8'h00);
    step(4'b0000, 1'b1, "idle_done");
    chk("idle_done.gnt", 8'(tif.gnt), 8'h00);
    chk("idle_done.id", 8'(tif.gnt_id), 8'h03);
    step(4'b1001, 1'b1, "idle_done_req");
    chk("idle_done_req.gnt", 8'(tif.gnt), 8'h01);

    // Reset asserted mid-grant
    step(4'b1000, 1'b1, "pre_mid");
    step(4'b1000, 1'b0, "pre_mid2");
    chk("pre_mid2.gnt", 8'(tif.gnt), 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.gnt", 8'(tif.gnt), 8'h00);
    chk("mid_rst.vld", 8'(tif.gnt_vld), 8'h00);
    chk("mid_rst.id", 8'(tif.gnt_id), 8'h00);
    model_reset();
    #1;
    rst_n = 1'b1;
    step(4'b1111, 1'b0, "post_rst");
    chk("post_rst.gnt", 8'(tif.gnt), 8'h01);

    // Randomized traffic against the model
    r = 4'b1111;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 5) == 0);
      step(r, d, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
